// File: rtl/password_check_controller_if.sv
// password_check_controller_if: entry/control inputs and status outputs of the password check sequencer
interface password_check_controller_if;
  logic        tick_1hz;
  logic        start;
  logic        submit;
  logic        clear;
  logic [13:0] guess;
  logic [13:0] master_password;
  logic [2:0]  state;
  logic        entry_enable;
  logic        unlocked;
  logic        denied;
  logic        locked_out;
  logic [2:0]  attempts_left;
  logic [6:0]  lockout_remaining;
  modport master (
    output tick_1hz, start, submit, clear, guess, master_password,
    input  state, entry_enable, unlocked, denied, locked_out, attempts_left, lockout_remaining
  );
  modport slave (
    input  tick_1hz, start, submit, clear, guess, master_password,
    output state, entry_enable, unlocked, denied, locked_out, attempts_left, lockout_remaining
  );
endinterface

// File: rtl/password_check_controller.sv
// password_check_controller: password check sequencer with attempt counting; timed lockout enabled by PWCHECK_LOCKOUT_EN
module password_check_controller #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCKOUT_SECS = 30,
  parameter int DENY_TICKS   = 2
) (
  input logic basys_clk,
  input logic reset_n,
  password_check_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    GRANTED = 3'd3,
    DENIED  = 3'd4,
    LOCKOUT = 3'd5
  } state_t;
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 7 || LOCKOUT_SECS < 1 || LOCKOUT_SECS > 99 || DENY_TICKS < 1 || DENY_TICKS > 255) begin : g_bad_param
    $error("password_check_controller: parameter out of legal range");
  end
  localparam logic [2:0] max_a  = 3'(MAX_ATTEMPTS);
  localparam logic [7:0] deny_n = 8'(DENY_TICKS);
  state_t      st, st_n;
  logic [2:0]  att, att_n;
  logic [13:0] gq, gq_n;
  logic [7:0]  tc, tc_n;
  logic        match;
  assign match = gq == bus.master_password && gq <= 14'd9999;
`ifdef PWCHECK_LOCKOUT_EN
  localparam logic [6:0] lock_n = 7'(LOCKOUT_SECS);
  logic [6:0] lr, lr_n;
  // lockout seconds counter
  always_ff @(posedge basys_clk or negedge reset_n)
    if (!reset_n) lr <= '0;
    else lr <= lr_n;
  assign bus.locked_out        = st == LOCKOUT;
  assign bus.lockout_remaining = lr;
`else
  assign bus.locked_out        = 1'b0;
  assign bus.lockout_remaining = '0;
`endif
  // state, attempts, guess latch and deny tick counter
  always_ff @(posedge basys_clk or negedge reset_n)
    if (!reset_n) begin
      st  <= IDLE;
      att <= max_a;
      gq  <= '0;
      tc  <= '0;
    end else begin
      st  <= st_n;
      att <= att_n;
      gq  <= gq_n;
      tc  <= tc_n;
    end
  // next state; clear overrides every other event
  always_comb begin
    st_n  = st;
    att_n = att;
    gq_n  = gq;
    tc_n  = tc;
`ifdef PWCHECK_LOCKOUT_EN
    lr_n  = lr;
`endif
    if (bus.clear) begin
      st_n  = IDLE;
      att_n = max_a;
      tc_n  = '0;
`ifdef PWCHECK_LOCKOUT_EN
      lr_n  = '0;
`endif
    end else begin
      unique case (st)
        IDLE: if (bus.start) begin
          st_n  = ENTRY;
          att_n = max_a;
        end
        ENTRY: if (bus.submit) begin
          st_n = CHECK;
          gq_n = bus.guess;
        end
        CHECK: begin
          st_n  = match ? GRANTED : DENIED;
          att_n = match || att == 3'd0 ? att : att - 3'd1;
          tc_n  = '0;
        end
        DENIED: if (bus.tick_1hz) begin
          tc_n = tc + 8'd1;
          if (tc + 8'd1 == deny_n) begin
            tc_n = '0;
`ifdef PWCHECK_LOCKOUT_EN
            st_n = att == 3'd0 ? LOCKOUT : ENTRY;
            lr_n = att == 3'd0 ? lock_n : lr;
`else
            st_n = ENTRY;
`endif
          end
        end
`ifdef PWCHECK_LOCKOUT_EN
        LOCKOUT: if (bus.tick_1hz) begin
          lr_n  = lr - 7'd1;
          st_n  = lr == 7'd1 ? ENTRY : LOCKOUT;
          att_n = lr == 7'd1 ? max_a : att;
        end
`endif
        default: ;
      endcase
    end
  end
  assign bus.state         = st;
  assign bus.entry_enable  = st == ENTRY;
  assign bus.unlocked      = st == GRANTED;
  assign bus.denied        = st == DENIED;
  assign bus.attempts_left = att;
endmodule

// File: tb/tb_password_check_controller.sv
// tb_password_check_controller: directed self-checking bench; lockout section follows PWCHECK_LOCKOUT_EN
module tb_password_check_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  password_check_controller_if bus();
  password_check_controller dut (
    .basys_clk(clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tick();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    step();
  endtask
  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic submit_guess(input int g);
    bus.guess  = 14'(g);
    bus.submit = 1'b1;
    step();
    bus.submit = 1'b0;
  endtask
  initial begin
    bus.tick_1hz = 1'b0;
    bus.start = 1'b0;
    bus.submit = 1'b0;
    bus.clear = 1'b0;
    bus.guess = '0;
    bus.master_password = 14'd1234;
    step(2);
    chk("rst_state", bus.state, 0);
    chk("rst_entry_en", bus.entry_enable, 0);
    chk("rst_unlocked", bus.unlocked, 0);
    chk("rst_denied", bus.denied, 0);
    chk("rst_locked", bus.locked_out, 0);
    chk("rst_attempts", bus.attempts_left, 3);
    chk("rst_lock_rem", bus.lockout_remaining, 0);
    rst_n = 1'b1;
    submit_guess(1234);
    chk("submit_in_idle", bus.state, 0);
    go();
    chk("start_state", bus.state, 1);
    chk("start_entry_en", bus.entry_enable, 1);
    submit_guess(1234);
    bus.guess = 14'd9;
    chk("ok_check", bus.state, 2);
    step();
    chk("ok_state", bus.state, 3);
    chk("ok_unlocked", bus.unlocked, 1);
    chk("ok_attempts", bus.attempts_left, 3);
    chk("ok_entry_en", bus.entry_enable, 0);
    submit_guess(1111);
    tick();
    chk("granted_sticky", bus.state, 3);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_state", bus.state, 0);
    go();
    submit_guess(1111);
    chk("bad1_check", bus.state, 2);
    step();
    chk("bad1_state", bus.state, 4);
    chk("bad1_denied", bus.denied, 1);
    chk("bad1_attempts", bus.attempts_left, 2);
    tick();
    chk("bad1_hold", bus.state, 4);
    tick();
    chk("bad1_back", bus.state, 1);
    submit_guess(2222);
    chk("bad2_check", bus.state, 2);
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    chk("bad2_state", bus.state, 4);
    chk("bad2_attempts", bus.attempts_left, 1);
    tick();
    chk("entry_tick_ignored", bus.state, 4);
    tick();
    chk("bad2_back", bus.state, 1);
    bus.master_password = 14'd12000;
    submit_guess(12000);
    step();
    chk("oor_state", bus.state, 4);
    chk("oor_unlocked", bus.unlocked, 0);
    chk("oor_attempts", bus.attempts_left, 0);
    bus.master_password = 14'd1234;
    tick();
    tick();
`ifdef PWCHECK_LOCKOUT_EN
    chk("lock_state", bus.state, 5);
    chk("lock_flag", bus.locked_out, 1);
    chk("lock_rem", bus.lockout_remaining, 30);
    chk("lock_entry_en", bus.entry_enable, 0);
    submit_guess(1234);
    chk("lock_submit_ign", bus.state, 5);
    tick();
    chk("lock_rem_29", bus.lockout_remaining, 29);
    repeat (28) tick();
    chk("lock_rem_1", bus.lockout_remaining, 1);
    chk("lock_still", bus.state, 5);
    tick();
    chk("lock_exit", bus.state, 1);
    chk("lock_exit_att", bus.attempts_left, 3);
    chk("lock_exit_rem", bus.lockout_remaining, 0);
    chk("lock_exit_flag", bus.locked_out, 0);
`else
    chk("nolock_state", bus.state, 1);
    chk("nolock_flag", bus.locked_out, 0);
    chk("nolock_rem", bus.lockout_remaining, 0);
    chk("nolock_att", bus.attempts_left, 0);
    submit_guess(1);
    step();
    chk("bad4_state", bus.state, 4);
    chk("bad4_att_sat", bus.attempts_left, 0);
    tick();
    tick();
    chk("bad4_back", bus.state, 1);
    chk("bad4_flag", bus.locked_out, 0);
`endif
    bus.guess = 14'd1234;
    bus.clear = 1'b1;
    bus.submit = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.submit = 1'b0;
    chk("clr_sub_state", bus.state, 0);
    chk("clr_sub_att", bus.attempts_left, 3);
    step();
    chk("clr_sub_no_check", bus.state, 0);
    go();
    submit_guess(5);
    step();
    chk("pre_rst_att", bus.attempts_left, 2);
    tick();
    tick();
    submit_guess(5);
    chk("pre_rst_check", bus.state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", bus.state, 0);
    chk("async_rst_att", bus.attempts_left, 3);
    chk("async_rst_entry", bus.entry_enable, 0);
    chk("async_rst_denied", bus.denied, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", bus.state, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/password_check_controller.md
# password_check_controller

Sequencer for the password check on slave boards. It gates the digit-entry datapath, latches a submitted 4-digit guess and compares it with the master password. It counts failed attempts and enforces a timed lockout. It sits between the password-entry logic (digits, `selected_password`) and the game-state logic, and drives the entry-enable and status outputs used by the OLED and LED layers.

## Interface
Parameters:
- `MAX_ATTEMPTS`, 3: failed submissions allowed before lockout; legal range 1–7.
- `LOCKOUT_SECS`, 30: lockout duration in 1 Hz ticks; legal range 1–99.
- `DENY_TICKS`, 2: 1 Hz ticks the DENIED state is held before returning to entry.

Ports:
- `basys_clk` in 1: 100 MHz system clock; the only clock.
- `reset_n` in 1: asynchronous active-low reset.
- `tick_1hz` in 1: single-cycle strobe at 1 Hz, synchronous to `basys_clk`.
- `start` in 1: single-cycle pulse that begins a check session.
- `submit` in 1: single-cycle pulse (debounced btnC) that submits the current guess.
- `clear` in 1: single-cycle pulse that abandons the session and returns to IDLE.
- `guess` in 14: entered password, 0–9999.
- `master_password` in 14: reference password, 0–9999.
- `state` out 3: IDLE=0, ENTRY=1, CHECK=2, GRANTED=3, DENIED=4, LOCKOUT=5.
- `entry_enable` out 1: high only in ENTRY; drives the digit-select enable.
- `unlocked` out 1: high in GRANTED.
- `denied` out 1: high in DENIED.
- `locked_out` out 1: high in LOCKOUT.
- `attempts_left` out 3: remaining attempts.
- `lockout_remaining` out 7: seconds left in LOCKOUT, otherwise 0.

## Operation
- Reset values:
  - `state`=IDLE.
  - `entry_enable`, `unlocked`, `denied`, `locked_out` = 0.
  - `attempts_left`=MAX_ATTEMPTS.
  - `lockout_remaining`=0.
  - Internal guess latch = 0; tick counter = 0.
- IDLE:
  - `start` → ENTRY.
  - `attempts_left` is reloaded to MAX_ATTEMPTS on this transition.
- ENTRY:
  - `submit` → CHECK.
  - `guess` is latched on the submit cycle; later changes to `guess` do not affect the result.
- CHECK: lasts exactly one cycle.
  - Match: latched guess == `master_password` and both ≤ 9999 → GRANTED.
  - Any value > 9999 counts as a mismatch.
  - Mismatch: `attempts_left` decrements by 1 (saturating at 0) → DENIED.
- GRANTED: sticky; left only via `clear` or reset.
- DENIED:
  - Counts `DENY_TICKS` ticks of `tick_1hz`.
  - Then → LOCKOUT if `attempts_left`==0, else → ENTRY.
- LOCKOUT:
  - On entry, `lockout_remaining` loads LOCKOUT_SECS.
  - Each tick decrements it by 1.
  - On the tick that takes it from 1 to 0 → ENTRY, with `attempts_left` reloaded to MAX_ATTEMPTS.
- `clear`: in any state → IDLE, with `attempts_left`=MAX_ATTEMPTS and `lockout_remaining`=0.
- Priority order: reset > `clear` > `submit`/`start`/`tick_1hz`.
- `submit` outside ENTRY is ignored and never queued. `start` outside IDLE is ignored.
- A tick in the same cycle as the DENIED or LOCKOUT entry transition is not counted; counting starts the cycle after entry.
- All outputs are registered and derived from the state register. No combinational path from inputs to outputs.

## Timing
- `submit` in cycle N: CHECK in N+1; GRANTED or DENIED in N+2, with `unlocked`/`denied` visible in N+2.
- `attempts_left` updates in the same cycle `denied` rises.
- DENIED duration: DENY_TICKS tick strobes (about DENY_TICKS s); the exit happens the cycle after the last counted strobe.
- LOCKOUT duration: LOCKOUT_SECS tick strobes. `lockout_remaining` updates the cycle after each strobe.
- `clear` in cycle N: IDLE in N+1.
- Reset deassertion: the first transition can occur on the first clock edge after `reset_n` rises.
- Asserting reset mid-operation (including in CHECK) clears all state immediately, with no clock edge needed.

## Configuration
- Macro: `PWCHECK_LOCKOUT_EN`.
- Defined:
  - Full behaviour as above.
  - LOCKOUT state and `lockout_remaining` are active.
- Undefined:
  - LOCKOUT is never entered. DENIED always returns to ENTRY.
  - `attempts_left` still decrements and saturates at 0, but does not gate entry.
  - `locked_out` and `lockout_remaining` are tied to 0.
  - The lockout counter is not synthesized.

## Test plan
- Correct guess: reset, `start`, guess=1234, master=1234, `submit` → `unlocked`=1 two cycles after submit; `attempts_left`=3; `entry_enable`=0.
- Wrong guess: guess=1111, master=1234, `submit` → `denied`=1 with `attempts_left`=2; after 2 ticks, state=ENTRY.
- Lockout: three wrong submits → LOCKOUT with `lockout_remaining`=30; after 30 ticks → ENTRY with `attempts_left`=3. `submit` during lockout is ignored.
- Out of range: guess=12000 with master=12000 → DENIED, not GRANTED.
- Simultaneous events: `clear` and `submit` in the same ENTRY cycle → IDLE next cycle, no CHECK. Reset asserted in CHECK → all outputs at reset values before the next edge.
- With `PWCHECK_LOCKOUT_EN` undefined: four wrong submits → `attempts_left`=0, state returns to ENTRY each time, `locked_out` stays 0.
